// File: rtl/cml_frame_gen_if.sv
// Pixel stream input and Camera Link output bundle for cml_frame_gen.
// master is the stream source / CML sink side; slave is the generator.
interface cml_frame_gen_if #(
    parameter int DW = 8
);
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tuser;
    logic          s_tlast;
    logic          cml_fval;
    logic          cml_lval;
    logic          cml_dval;
    logic [DW-1:0] cml_data;

    modport master (
        output s_tdata, s_tvalid, s_tuser, s_tlast,
        input  s_tready, cml_fval, cml_lval, cml_dval, cml_data
    );

    modport slave (
        input  s_tdata, s_tvalid, s_tuser, s_tlast,
        output s_tready, cml_fval, cml_lval, cml_dval, cml_data
    );
endinterface

// File: rtl/cml_frame_gen.sv
// Camera Link frame timing generator and tap packer: builds FVAL/LVAL/DVAL
// timing around a pixel stream or an internal ramp, with sync checking.
module cml_frame_gen #(
    parameter int ROW         = 1024,
    parameter int COL         = 1280,
    parameter int PIXEL_WIDTH = 8,
    parameter int TAPS        = 1,
    parameter int FV_LEAD     = 2,
    parameter int HBLANK      = 16,
    parameter int VBLANK      = 64
) (
    input  logic                video_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                test_mode,
    cml_frame_gen_if.slave      bus,
    output logic                frame_done,
    output logic                sync_err,
    output logic [15:0]         frame_cnt
);
    localparam int DW   = TAPS * PIXEL_WIDTH;
    localparam int BPL  = COL / TAPS;
    localparam int MAXB = (FV_LEAD > HBLANK) ? ((FV_LEAD > VBLANK) ? FV_LEAD : VBLANK)
                                             : ((HBLANK > VBLANK) ? HBLANK : VBLANK);
    localparam int RW   = (ROW  > 1) ? $clog2(ROW)  : 1;
    localparam int CW   = (BPL  > 1) ? $clog2(BPL)  : 1;
    localparam int BW   = (MAXB > 1) ? $clog2(MAXB) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LEAD, S_LINE, S_HBLANK, S_VBLANK} state_t;

    state_t        state, state_nxt;
    logic [BW-1:0] blank_cnt, blank_nxt;
    logic [RW-1:0] row_cnt, row_nxt;
    logic [CW-1:0] col_cnt, col_nxt;
    logic          tm_q, tm_nxt;
    logic          beat;
    logic          in_frame;
    logic          vblank_first;
    logic          sof_pos, eol_pos;
    logic [DW-1:0] ramp;

    always_ff @(posedge video_clk) begin
        if (reset) begin
            state     <= S_IDLE;
            blank_cnt <= '0;
            row_cnt   <= '0;
            col_cnt   <= '0;
            tm_q      <= 1'b0;
        end else begin
            state     <= state_nxt;
            blank_cnt <= blank_nxt;
            row_cnt   <= row_nxt;
            col_cnt   <= col_nxt;
            tm_q      <= tm_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        blank_nxt = blank_cnt;
        row_nxt   = row_cnt;
        col_nxt   = col_cnt;
        tm_nxt    = tm_q;
        beat      = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    tm_nxt    = test_mode;
                    state_nxt = S_LEAD;
                end
            end
            S_LEAD: begin
                if (blank_cnt == BW'(FV_LEAD - 1)) begin
                    blank_nxt = '0;
                    state_nxt = S_LINE;
                end else begin
                    blank_nxt = blank_cnt + BW'(1);
                end
            end
            S_LINE: begin
                // An idle stream cycle keeps LVAL high and simply stretches the line.
                beat = tm_q | bus.s_tvalid;
                if (beat) begin
                    if (col_cnt == CW'(BPL - 1)) begin
                        col_nxt = '0;
                        if (row_cnt == RW'(ROW - 1)) begin
                            row_nxt   = '0;
                            state_nxt = S_VBLANK;
                        end else begin
                            row_nxt   = row_cnt + RW'(1);
                            state_nxt = S_HBLANK;
                        end
                    end else begin
                        col_nxt = col_cnt + CW'(1);
                    end
                end
            end
            S_HBLANK: begin
                if (blank_cnt == BW'(HBLANK - 1)) begin
                    blank_nxt = '0;
                    state_nxt = S_LINE;
                end else begin
                    blank_nxt = blank_cnt + BW'(1);
                end
            end
            S_VBLANK: begin
                if (blank_cnt == BW'(VBLANK - 1)) begin
                    blank_nxt = '0;
                    if (enable) begin
                        tm_nxt    = test_mode;
                        state_nxt = S_LEAD;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end else begin
                    blank_nxt = blank_cnt + BW'(1);
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ramp = '0;
        for (int k = 0; k < TAPS; k++)
            ramp[k*PIXEL_WIDTH +: PIXEL_WIDTH] =
                PIXEL_WIDTH'(int'(col_cnt) * TAPS + k + int'(row_cnt));
    end

    assign bus.s_tready = (state == S_LINE) && !tm_q;
    assign in_frame     = (state == S_LEAD) || (state == S_LINE) || (state == S_HBLANK);
    assign vblank_first = (state == S_VBLANK) && (blank_cnt == '0);
    assign sof_pos      = (row_cnt == '0) && (col_cnt == '0);
    assign eol_pos      = (col_cnt == CW'(BPL - 1));

    // Outputs trail the FSM by one cycle, so frame_done lines up with FVAL falling.
    always_ff @(posedge video_clk) begin
        if (reset) begin
            bus.cml_fval <= 1'b0;
            bus.cml_lval <= 1'b0;
            bus.cml_dval <= 1'b0;
            bus.cml_data <= '0;
            frame_done   <= 1'b0;
            sync_err     <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            bus.cml_fval <= in_frame;
            bus.cml_lval <= (state == S_LINE);
            bus.cml_dval <= beat;
            if (!in_frame)
                bus.cml_data <= '0;
            else if (beat)
                bus.cml_data <= tm_q ? ramp : bus.s_tdata;
            frame_done <= vblank_first;
            if (vblank_first)
                frame_cnt <= frame_cnt + 16'd1;
            sync_err <= (state == S_LINE) && !tm_q && bus.s_tvalid &&
                        ((bus.s_tuser != sof_pos) || (bus.s_tlast != eol_pos));
        end
    end
endmodule
